// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the configuration loader.
// Contents:
//   - default geometry of the fabric configuration array
//   - loader state enum
//   - wpr(): number of stream words that make up one configuration row
package fpga_cfg_pkg;

   localparam int DEF_ROW_W    = 320;
   localparam int DEF_NUM_ROWS = 172;
   localparam int DEF_WORD_W   = 32;
   localparam int DEF_SETTLE   = 10;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      APPLY,
      SETTLE_CFG,
      SETTLE_FF,
      DONE
   } state_e;

   function automatic int wpr(input int row_w, input int word_w);
      return row_w / word_w;
   endfunction

endpackage

// File: rtl/fpga_cfg_loader_if.sv
// Bitstream word stream with a valid/ready handshake.
// A word transfers on a rising clock edge where in_valid & in_ready.
//   master : drives in_data / in_valid, receives in_ready (bitstream source)
//   slave  : receives in_data / in_valid, drives in_ready (the loader)
interface fpga_cfg_loader_if
   import fpga_cfg_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W
);
   logic [WORD_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;

   modport master (output in_data, output in_valid, input  in_ready);
   modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/fpga_cfg_row_asm.sv
// Assembles WORD_W-bit stream words into one ROW_W-bit configuration row.
// Word k of a row lands in bits [k*WORD_W +: WORD_W]: words enter at the MSB
// end of a right-shifting buffer. The buffer keeps the previous WPR-1 words;
// the WPR-th word is joined combinationally so the row is available on the
// same edge that accepts its last word. Requires ROW_W >= 2*WORD_W.
// Ports:
//   clock, rst : clock and asynchronous active-low reset
//   clr        : restart the word count for a new row
//   xfer       : a word is transferred this cycle
//   word       : the word being transferred
//   row_full   : this transfer completes the row
//   row_data   : assembled row (valid when row_full)
module fpga_cfg_row_asm
   import fpga_cfg_pkg::*;
#(
   parameter int ROW_W  = DEF_ROW_W,
   parameter int WORD_W = DEF_WORD_W
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              clr,
   input  logic              xfer,
   input  logic [WORD_W-1:0] word,
   output logic              row_full,
   output logic [ROW_W-1:0]  row_data
);
   localparam int WPR   = wpr(ROW_W, WORD_W);
   localparam int BUF_W = ROW_W - WORD_W;
   localparam int CNT_W = $clog2(WPR + 1);

   logic [BUF_W-1:0] buf_q, buf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign row_data = {word, buf_q};
   assign row_full = xfer && (cnt_q == CNT_W'(WPR - 1));

   always_comb begin
      buf_d = buf_q;
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (xfer) begin
         // Only a real transfer moves data, so an undriven in_data never
         // reaches the buffer.
         buf_d = row_data[ROW_W-1:WORD_W];
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         // NOTE: the buffer is a few hundred flops, not a RAM, so resetting
         // it is cheap and keeps configs_in free of unknowns after reset.
         buf_q <= '0;
         cnt_q <= '0;
      end else begin
         buf_q <= buf_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fpga_cfg_loader.sv
// Configuration loader upstream of the fpga fabric top.
// Pulls the bitstream from a valid/ready word stream, assembles rows and
// presents each row on configs_in with a one-hot configs_en walking from
// row 0 upward. After the last row it waits SETTLE cycles, raises ff_en,
// waits SETTLE more cycles and raises rdy.
// Ports:
//   clock, rst  : clock and asynchronous active-low reset
//   start       : one-cycle load request, honoured in IDLE or DONE
//   stream      : bitstream word stream (slave side)
//   configs_in  : row data to the fabric
//   configs_en  : one-hot row enable to the fabric
//   ff_en, rdy  : fabric flip-flop enable, configuration complete
//   busy        : load in progress
//   row_idx     : row currently being assembled
module fpga_cfg_loader
   import fpga_cfg_pkg::*;
#(
   parameter int ROW_W    = DEF_ROW_W,
   parameter int NUM_ROWS = DEF_NUM_ROWS,
   parameter int WORD_W   = DEF_WORD_W,
   parameter int SETTLE   = DEF_SETTLE
) (
   input  logic                        clock,
   input  logic                        rst,
   input  logic                        start,
   fpga_cfg_loader_if.slave            stream,
   output logic [ROW_W-1:0]            configs_in,
   output logic [NUM_ROWS-1:0]         configs_en,
   output logic                        ff_en,
   output logic                        rdy,
   output logic                        busy,
   output logic [$clog2(NUM_ROWS)-1:0] row_idx
);
   localparam int IDX_W = $clog2(NUM_ROWS);
   localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   state_e              state_q, state_d;
   logic [ROW_W-1:0]    configs_in_q, configs_in_d;
   logic [NUM_ROWS-1:0] configs_en_q, configs_en_d;
   logic [IDX_W-1:0]    row_idx_q, row_idx_d;
   logic [SET_W-1:0]    settle_q, settle_d;
   logic                ff_en_q, ff_en_d;
   logic                rdy_q, rdy_d;
   logic                in_ready_q, in_ready_d;
   logic                busy_q, busy_d;

   logic                xfer;
   logic                asm_clr;
   logic                row_full;
   logic [ROW_W-1:0]    row_data;

   // in_ready_q is high exactly in FILL, so this is the FILL-state transfer.
   assign xfer = stream.in_valid && in_ready_q;

   fpga_cfg_row_asm #(
      .ROW_W  (ROW_W),
      .WORD_W (WORD_W)
   ) u_row_asm (
      .clock    (clock),
      .rst      (rst),
      .clr      (asm_clr),
      .xfer     (xfer),
      .word     (stream.in_data),
      .row_full (row_full),
      .row_data (row_data)
   );

   always_comb begin
      // NOTE: every _d starts as its _q, so no branch leaves a variable
      // unassigned and no latch is inferred.
      state_d      = state_q;
      configs_in_d = configs_in_q;
      configs_en_d = configs_en_q;
      row_idx_d    = row_idx_q;
      settle_d     = settle_q;
      ff_en_d      = ff_en_q;
      rdy_d        = rdy_q;
      asm_clr      = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d      = FILL;
               configs_en_d = NUM_ROWS'(1);
               row_idx_d    = '0;
               ff_en_d      = 1'b0;
               rdy_d        = 1'b0;
               asm_clr      = 1'b1;
            end
         end
         FILL: begin
            // configs_in moves only here, so it is stable through APPLY and
            // after the enable shift.
            if (row_full) begin
               configs_in_d = row_data;
               state_d      = APPLY;
            end
         end
         APPLY: begin
            asm_clr = 1'b1;
            if (row_idx_q == IDX_W'(NUM_ROWS - 1)) begin
               configs_en_d = '0;
               settle_d     = '0;
               state_d      = SETTLE_CFG;
            end else begin
               configs_en_d = configs_en_q << 1;
               row_idx_d    = row_idx_q + IDX_W'(1);
               state_d      = FILL;
            end
         end
         SETTLE_CFG: begin
            if (settle_q == SET_W'(SETTLE - 1)) begin
               settle_d = '0;
               ff_en_d  = 1'b1;
               state_d  = SETTLE_FF;
            end else begin
               settle_d = settle_q + SET_W'(1);
            end
         end
         SETTLE_FF: begin
            if (settle_q == SET_W'(SETTLE - 1)) begin
               settle_d = '0;
               rdy_d    = 1'b1;
               state_d  = DONE;
            end else begin
               settle_d = settle_q + SET_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Handshake and status follow the next state so they are registered.
      in_ready_d = (state_d == FILL);
      busy_d     = (state_d != IDLE) && (state_d != DONE);
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         configs_in_q <= '0;
         configs_en_q <= NUM_ROWS'(1);
         row_idx_q    <= '0;
         settle_q     <= '0;
         ff_en_q      <= 1'b0;
         rdy_q        <= 1'b0;
         in_ready_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         // NOTE: non-blocking updates make every flop load its pre-edge
         // value, independent of statement order.
         state_q      <= state_d;
         configs_in_q <= configs_in_d;
         configs_en_q <= configs_en_d;
         row_idx_q    <= row_idx_d;
         settle_q     <= settle_d;
         ff_en_q      <= ff_en_d;
         rdy_q        <= rdy_d;
         in_ready_q   <= in_ready_d;
         busy_q       <= busy_d;
      end
   end

   assign stream.in_ready = in_ready_q;
   assign configs_in      = configs_in_q;
   assign configs_en      = configs_en_q;
   assign row_idx         = row_idx_q;
   assign ff_en           = ff_en_q;
   assign rdy             = rdy_q;
   assign busy            = busy_q;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Self-checking bench for fpga_cfg_loader. Two instances: a small one
// (64-bit rows, 4 rows, settle 3) and one with default geometry. A model
// derives, from the word list and the in_valid pattern, when each row
// completes, and from those times the expected value of every output on
// every cycle of a load.
module tb_fpga_cfg_loader;
   localparam int MW   = 320;
   localparam int MR   = 172;
   localparam int MAXC = 4096;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_s, rst_b;
   logic        tb_start, tb_valid;
   logic [31:0] tb_data;
   int          sel;

   int checks   = 0;
   int failures = 0;
   int load_no  = 0;

   int          p_rows, p_wpr, p_settle;
   logic [31:0] wq[$];
   bit          vpat[MAXC];
   int          fe[MR];

   fpga_cfg_loader_if #(.WORD_W(32)) s_if ();
   fpga_cfg_loader_if #(.WORD_W(32)) b_if ();

   assign s_if.in_valid = (sel == 0) && tb_valid;
   assign b_if.in_valid = (sel == 1) && tb_valid;
   assign s_if.in_data  = tb_data;
   assign b_if.in_data  = tb_data;

   logic        start_s, start_b;
   assign start_s = (sel == 0) && tb_start;
   assign start_b = (sel == 1) && tb_start;

   logic [63:0]  s_cin;
   logic [3:0]   s_en;
   logic [1:0]   s_idx;
   logic         s_ff, s_rdy, s_busy;
   logic [319:0] b_cin;
   logic [171:0] b_en;
   logic [7:0]   b_idx;
   logic         b_ff, b_rdy, b_busy;

   fpga_cfg_loader #(.ROW_W(64), .NUM_ROWS(4), .WORD_W(32), .SETTLE(3)) u_small (
      .clock(clk), .rst(rst_s), .start(start_s), .stream(s_if),
      .configs_in(s_cin), .configs_en(s_en), .ff_en(s_ff), .rdy(s_rdy),
      .busy(s_busy), .row_idx(s_idx)
   );

   fpga_cfg_loader u_big (
      .clock(clk), .rst(rst_b), .start(start_b), .stream(b_if),
      .configs_in(b_cin), .configs_en(b_en), .ff_en(b_ff), .rdy(b_rdy),
      .busy(b_busy), .row_idx(b_idx)
   );

   logic [MW-1:0] obs_cin, obs_en, obs_idx;
   logic          obs_ready, obs_ff, obs_rdy, obs_busy;
   assign obs_cin   = (sel == 0) ? MW'(s_cin) : MW'(b_cin);
   assign obs_en    = (sel == 0) ? MW'(s_en)  : MW'(b_en);
   assign obs_idx   = (sel == 0) ? MW'(s_idx) : MW'(b_idx);
   assign obs_ready = (sel == 0) ? s_if.in_ready : b_if.in_ready;
   assign obs_ff    = (sel == 0) ? s_ff   : b_ff;
   assign obs_rdy   = (sel == 0) ? s_rdy  : b_rdy;
   assign obs_busy  = (sel == 0) ? s_busy : b_busy;

   task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tg);
      check({tg, " configs_in"}, obs_cin, '0);
      check({tg, " configs_en"}, obs_en, MW'(1));
      check({tg, " ff_en"}, MW'(obs_ff), '0);
      check({tg, " rdy"}, MW'(obs_rdy), '0);
      check({tg, " in_ready"}, MW'(obs_ready), '0);
      check({tg, " busy"}, MW'(obs_busy), '0);
      check({tg, " row_idx"}, obs_idx, '0);
   endtask

   // Row r is words r*WPR .. r*WPR+WPR-1, word k in bits [k*32 +: 32].
   function automatic logic [MW-1:0] exp_row(input int r);
      logic [MW-1:0] v;
      v = '0;
      for (int k = 0; k < p_wpr; k++) v[k*32 +: 32] = wq[r*p_wpr + k];
      return v;
   endfunction

   // mode: 0 in_valid always high, 1 toggling (high on odd edges), 2 random.
   // again_off >= 0 pulses start that many cycles into SETTLE_CFG.
   task automatic run_load(input int which, input int mode, input bit fixed_words,
                           input bit do_abort, input int again_off,
                           input logic [MW-1:0] prev_in, output logic [MW-1:0] last_in);
      int nw, k, e, r, ptr, t_last, t_ff, t_rdy, abort_at, again_at;
      bit aborted;
      logic [MW-1:0] e_cin, e_en;
      logic e_ready, e_busy, e_ff, e_rdy;
      int e_idx;
      string tg;

      sel      = which;
      p_rows   = (which == 1) ? 172 : 4;
      p_wpr    = (which == 1) ? 10 : 2;
      p_settle = (which == 1) ? 10 : 3;
      load_no++;

      nw = p_rows * p_wpr;
      wq.delete();
      for (int i = 0; i < nw; i++)
         wq.push_back(fixed_words ? 32'(i + 1) * 32'h1111_1111 : $urandom);

      vpat[0] = 1'b0;
      for (int i = 1; i < MAXC; i++)
         vpat[i] = (mode == 0) ? 1'b1 : (mode == 1) ? bit'(i % 2) : bit'($urandom_range(0, 1));

      // Each row needs WPR valid cycles after it enters FILL, then one APPLY cycle.
      e = 0;
      for (int rr = 0; rr < p_rows; rr++) begin
         k = 0;
         while (k < p_wpr && e < MAXC - 1) begin
            e++;
            if (vpat[e]) k++;
         end
         fe[rr] = e;
         e++;
      end
      t_last   = fe[p_rows-1];
      t_ff     = t_last + 1 + p_settle;
      t_rdy    = t_last + 1 + 2 * p_settle;
      abort_at = do_abort ? fe[1] + 2 : -1;
      again_at = (again_off >= 0) ? t_last + 1 + again_off : -1;

      @(negedge clk);
      tb_start = 1'b1;
      tb_valid = 1'b0;
      tb_data  = 'x;
      r = 0; ptr = 0; aborted = 1'b0;

      for (int c = 0; c <= t_rdy + 2 && !aborted; c++) begin
         @(negedge clk);
         while (r < p_rows - 1 && c > fe[r]) r++;
         if (c <= t_last) begin
            e_en = '0; e_en[r] = 1'b1;
            e_idx = r; e_busy = 1'b1; e_ready = (c < fe[r]); e_ff = 1'b0; e_rdy = 1'b0;
            if (c >= fe[r])  e_cin = exp_row(r);
            else if (r == 0) e_cin = prev_in;
            else             e_cin = exp_row(r - 1);
         end else begin
            e_en = '0; e_idx = p_rows - 1; e_ready = 1'b0; e_cin = exp_row(p_rows - 1);
            e_ff = (c >= t_ff); e_rdy = (c >= t_rdy); e_busy = (c < t_rdy);
         end
         tg = $sformatf("load%0d c%0d", load_no, c);
         check({tg, " configs_in"}, obs_cin, e_cin);
         check({tg, " configs_en"}, obs_en, e_en);
         check({tg, " in_ready"}, MW'(obs_ready), MW'(e_ready));
         check({tg, " busy"}, MW'(obs_busy), MW'(e_busy));
         check({tg, " ff_en"}, MW'(obs_ff), MW'(e_ff));
         check({tg, " rdy"}, MW'(obs_rdy), MW'(e_rdy));
         check({tg, " row_idx"}, obs_idx, MW'(e_idx));

         if (c == abort_at) begin
            tb_valid = 1'b0;
            tb_start = 1'b0;
            #2 rst_s = 1'b0;
            #1 check_reset({tg, " async_reset"});
            @(posedge clk);
            @(negedge clk);
            rst_s = 1'b1;
            #1 check_reset({tg, " after_reset"});
            aborted = 1'b1;
         end else begin
            tb_start = (c + 1 == again_at);
            tb_valid = vpat[c + 1];
            if (!tb_valid)    tb_data = 'x;
            else if (ptr < nw) tb_data = wq[ptr];
            else               tb_data = $urandom;
            // A registered in_ready seen now still holds at the next edge.
            if (tb_valid && obs_ready) ptr++;
         end
      end
      tb_start = 1'b0;
      tb_valid = 1'b0;
      tb_data  = 'x;
      last_in  = aborted ? '0 : exp_row(p_rows - 1);
   endtask

   initial begin
      logic [MW-1:0] last;
      rst_s = 1'b0; rst_b = 1'b0;
      tb_start = 1'b0; tb_valid = 1'b0; tb_data = 'x;
      sel = 0;
      repeat (2) @(negedge clk);
      check_reset("reset_small");
      sel = 1;
      #1 check_reset("reset_big");
      rst_s = 1'b1; rst_b = 1'b1;

      // 1: incrementing words, in_valid always high.
      run_load(0, 0, 1'b1, 1'b0, -1, '0, last);
      // 2: in_valid toggling, started from DONE.
      run_load(0, 1, 1'b0, 1'b0, -1, last, last);
      // 3: reset during row 2 FILL, then a fresh load from IDLE.
      run_load(0, 0, 1'b0, 1'b1, -1, last, last);
      run_load(0, 0, 1'b0, 1'b0, -1, '0, last);
      // 4: start during SETTLE_CFG is ignored; start in DONE reloads.
      run_load(0, 0, 1'b0, 1'b0, 1, last, last);
      run_load(0, 2, 1'b0, 1'b0, -1, last, last);
      // 5: default geometry, random words.
      run_load(1, 0, 1'b0, 1'b0, -1, '0, last);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
